// File: rtl/snitch_icache_lookup_plru.sv
// Instruction-cache lookup stage: flop-based tag/data arrays, tree pseudo-LRU victim
// selection and an index sweep that invalidates every set after reset or flush.

module snitch_icache_lookup_plru_way #(
    parameter int TAG_W = 8
) (
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [TAG_W-1:0] stored_tag_i,
    output logic             match_o
);
    assign match_o = valid_i && (tag_i == stored_tag_i);
endmodule

module snitch_icache_lookup_plru #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LINE_WIDTH = 128,
    parameter int LINE_COUNT = 16,
    parameter int WAY_COUNT  = 4,
    localparam int LINE_ALIGN = $clog2(LINE_WIDTH / 8),
    localparam int IDX_W      = $clog2(LINE_COUNT),
    localparam int LOG_W      = $clog2(WAY_COUNT),
    localparam int WAY_W      = (LOG_W > 0) ? LOG_W : 1,
    localparam int TAG_W      = ADDR_WIDTH - LINE_ALIGN - IDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_valid_i,
    output logic                  flush_ready_o,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [ID_WIDTH-1:0]   in_id_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [ID_WIDTH-1:0]   out_id_o,
    output logic                  out_hit_o,
    output logic [WAY_W-1:0]      out_way_o,
    output logic [LINE_WIDTH-1:0] out_data_o,
    output logic                  out_error_o,
    output logic [WAY_W-1:0]      out_victim_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    input  logic [IDX_W-1:0]      write_addr_i,
    input  logic [WAY_W-1:0]      write_way_i,
    input  logic [LINE_WIDTH-1:0] write_data_i,
    input  logic [TAG_W-1:0]      write_tag_i,
    input  logic                  write_error_i,
    input  logic                  write_valid_i,
    output logic                  write_ready_o
);
    localparam int PLRU_W = (WAY_COUNT > 1) ? WAY_COUNT - 1 : 1;

    typedef enum logic {SWEEP, IDLE} state_e;

    state_e                                 state_q, state_d;
    logic [IDX_W-1:0]                       cnt_q, cnt_d;
    logic [LINE_COUNT-1:0][WAY_COUNT-1:0]   valid_q, err_q;
    logic [LINE_COUNT-1:0][PLRU_W-1:0]      plru_q;
    logic [TAG_W-1:0]                       tag_q  [WAY_COUNT][LINE_COUNT];
    logic [LINE_WIDTH-1:0]                  data_q [WAY_COUNT][LINE_COUNT];

    logic                  out_valid_q, out_hit_q, out_err_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ID_WIDTH-1:0]   out_id_q;
    logic [WAY_W-1:0]      out_way_q, out_victim_q;
    logic [LINE_WIDTH-1:0] out_data_q;

    // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] s,
                                                     input logic [WAY_W-1:0]  w);
        logic [WAY_W-1:0] n;
        logic             b;
        plru_touch = s;
        n = '0;
        for (int l = 0; l < LOG_W; l++) begin
            b = w[LOG_W-1-l];
            plru_touch[n] = ~b;
            n = WAY_W'({n, 1'b1} + {{WAY_W{1'b0}}, b});
        end
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] s);
        logic [WAY_W-1:0] n;
        logic             b;
        plru_victim = '0;
        n = '0;
        for (int l = 0; l < LOG_W; l++) begin
            b = s[n];
            plru_victim[LOG_W-1-l] = b;
            n = WAY_W'({n, 1'b1} + {{WAY_W{1'b0}}, b});
        end
    endfunction

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WAY_COUNT-1:0]  match;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way, victim;
    logic                  write_hs, in_hs;

    assign idx      = in_addr_i[LINE_ALIGN +: IDX_W];
    assign tag      = in_addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign write_hs = write_valid_i && write_ready_o;
    assign in_hs    = in_valid_i && in_ready_o;

    for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
        snitch_icache_lookup_plru_way #(.TAG_W(TAG_W)) i_way (
            .valid_i      (valid_q[idx][w]),
            .tag_i        (tag),
            .stored_tag_i (tag_q[w][idx]),
            .match_o      (match[w])
        );
    end

    // Descending scans so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = plru_victim(plru_q[idx]);
        for (int w = WAY_COUNT - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) victim = WAY_W'(w);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_ready_o = 1'b0;
        write_ready_o = 1'b0;
        in_ready_o    = 1'b0;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(LINE_COUNT - 1)) state_d = IDLE;
            end
            IDLE: begin
                flush_ready_o = 1'b1;
                write_ready_o = !flush_valid_i;
                in_ready_o    = !flush_valid_i && !write_valid_i && (!out_valid_q || out_ready_i);
                if (flush_valid_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            valid_q <= '0;
            plru_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == SWEEP) begin
                valid_q[cnt_q] <= '0;
                plru_q[cnt_q]  <= '0;
            end else if (write_hs) begin
                valid_q[write_addr_i][write_way_i] <= 1'b1;
                plru_q[write_addr_i] <= plru_touch(plru_q[write_addr_i], write_way_i);
            end else if (in_hs && hit) begin
                plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            end
        end
    end

    // Payload arrays carry no reset; the valid bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (write_hs) begin
            tag_q[write_way_i][write_addr_i]  <= write_tag_i;
            data_q[write_way_i][write_addr_i] <= write_data_i;
            err_q[write_addr_i][write_way_i]  <= write_error_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_hit_q    <= 1'b0;
            out_err_q    <= 1'b0;
            out_way_q    <= '0;
            out_victim_q <= '0;
            out_addr_q   <= '0;
            out_id_q     <= '0;
            out_data_q   <= '0;
        end else if (in_hs) begin
            out_valid_q  <= 1'b1;
            out_hit_q    <= hit;
            out_err_q    <= hit && err_q[idx][hit_way];
            out_way_q    <= hit_way;
            out_victim_q <= victim;
            out_addr_q   <= in_addr_i;
            out_id_q     <= in_id_i;
            out_data_q   <= hit ? data_q[hit_way][idx] : '0;
        end else if (out_ready_i) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_hit_o    = out_hit_q;
    assign out_error_o  = out_err_q;
    assign out_way_o    = out_way_q;
    assign out_victim_o = out_victim_q;
    assign out_addr_o   = out_addr_q;
    assign out_id_o     = out_id_q;
    assign out_data_o   = out_data_q;

endmodule

// File: tb/tb_snitch_icache_lookup_plru.sv
// Randomized bench for snitch_icache_lookup_plru against a timestamp-based
// cache model (PLRU victim derived from per-way last-access times).

module tb_snitch_icache_lookup_plru;
    localparam int AW = 32, IW = 4, LW = 128, LC = 16, WC = 4, WW = 2, XW = 4, TW = 24;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic flush_valid = 0, flush_ready;
    logic [AW-1:0] in_addr = '0;
    logic [IW-1:0] in_id = '0;
    logic in_valid = 0, in_ready;
    logic [AW-1:0] out_addr;
    logic [IW-1:0] out_id;
    logic out_hit, out_error, out_valid, out_ready = 1;
    logic [WW-1:0] out_way, out_victim;
    logic [LW-1:0] out_data;
    logic [XW-1:0] write_addr = '0;
    logic [WW-1:0] write_way = '0;
    logic [LW-1:0] write_data = '0;
    logic [TW-1:0] write_tag = '0;
    logic write_error = 0, write_valid = 0, write_ready;

    snitch_icache_lookup_plru dut (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_valid_i(flush_valid), .flush_ready_o(flush_ready),
        .in_addr_i(in_addr), .in_id_i(in_id), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_addr_o(out_addr), .out_id_o(out_id), .out_hit_o(out_hit), .out_way_o(out_way),
        .out_data_o(out_data), .out_error_o(out_error), .out_victim_o(out_victim),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .write_addr_i(write_addr), .write_way_i(write_way), .write_data_i(write_data),
        .write_tag_i(write_tag), .write_error_i(write_error),
        .write_valid_i(write_valid), .write_ready_o(write_ready)
    );

    typedef struct packed {
        logic          v;
        logic          hit;
        logic [WW-1:0] way;
        logic [LW-1:0] data;
        logic          err;
        logic [WW-1:0] victim;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
    } res_t;

    int vectors = 0, miscompares = 0;

    // Reference model: contents plus time of last access per way.
    bit            m_valid [LC][WC];
    logic [TW-1:0] m_tag   [LC][WC];
    logic [LW-1:0] m_data  [LC][WC];
    bit            m_err   [LC][WC];
    longint        m_last  [LC][WC];
    longint        m_time = 0;

    function automatic void m_clear();
        for (int i = 0; i < LC; i++)
            for (int j = 0; j < WC; j++) begin m_valid[i][j] = 0; m_last[i][j] = 0; end
    endfunction

    // Tree PLRU equivalent: at each subtree go to the half that does not hold the
    // most recent access; with no access recorded in either half go low.
    function automatic int m_victim(int ix);
        int lo, size, half;
        longint lmax, umax;
        for (int w = 0; w < WC; w++) if (!m_valid[ix][w]) return w;
        lo = 0; size = WC;
        while (size > 1) begin
            half = size / 2; lmax = 0; umax = 0;
            for (int w = lo; w < lo + half; w++) if (m_last[ix][w] > lmax) lmax = m_last[ix][w];
            for (int w = lo + half; w < lo + size; w++) if (m_last[ix][w] > umax) umax = m_last[ix][w];
            if (lmax > umax) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    function automatic res_t m_lookup(logic [AW-1:0] a, logic [IW-1:0] id);
        res_t r;
        int ix;
        ix = int'(a[7:4]);
        r = '0; r.v = 1; r.addr = a; r.id = id;
        r.victim = WW'(m_victim(ix));
        for (int w = WC - 1; w >= 0; w--)
            if (m_valid[ix][w] && m_tag[ix][w] == a[31:8]) begin
                r.hit = 1; r.way = WW'(w); r.data = m_data[ix][w]; r.err = m_err[ix][w];
            end
        if (r.hit) begin m_time++; m_last[ix][r.way] = m_time; end
        return r;
    endfunction

    function automatic void m_write(int ix, int w, logic [TW-1:0] t, logic [LW-1:0] d, bit e);
        m_valid[ix][w] = 1; m_tag[ix][w] = t; m_data[ix][w] = d; m_err[ix][w] = e;
        m_time++; m_last[ix][w] = m_time;
    endfunction

    function automatic res_t get_res();
        return '{out_valid, out_hit, out_way, out_data, out_error, out_victim, out_addr, out_id};
    endfunction

    function automatic logic [AW-1:0] mk_addr(logic [TW-1:0] t, int ix);
        return {t, 4'(ix), 4'($urandom_range(15))};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(int ix, int w, logic [TW-1:0] t, logic [LW-1:0] d, bit e);
        int n = 0;
        write_addr = XW'(ix); write_way = WW'(w); write_tag = t; write_data = d;
        write_error = e; write_valid = 1; #1;
        while (!write_ready && n < 50) begin tick(); n++; end
        if (!write_ready) begin
            vectors++; miscompares++;
            $display("FAIL write_timeout: write_ready=%b required 1", write_ready);
        end
        tick(); write_valid = 0;
        m_write(ix, w, t, d, e);
    endtask

    task automatic do_lookup(logic [AW-1:0] a, logic [IW-1:0] id, output res_t obs);
        int n = 0;
        in_addr = a; in_id = id; in_valid = 1; out_ready = 1; #1;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL lookup_timeout: in_ready=%b required 1", in_ready);
        end
        tick(); in_valid = 0;
        obs = get_res();
    endtask

    task automatic test_reset();
        res_t r;
        repeat (3) tick();
        vectors++;
        if (get_res() !== '0 || {in_ready, write_ready, flush_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold: out=%h rdy=%b required 0/000", get_res(), {in_ready, write_ready, flush_ready});
        end
        rst_n = 1; #1;
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) tick();
            r = get_res();
            vectors++;
            if (r !== '0 || {in_ready, write_ready, flush_ready} !== (c == 17 ? 3'b111 : 3'b000)) begin
                miscompares++;
                $display("FAIL reset_sweep cycle %0d: out=%h rdy=%b required 0/%b", c, r,
                         {in_ready, write_ready, flush_ready}, (c == 17 ? 3'b111 : 3'b000));
            end
        end
        m_clear();
    endtask

    task automatic test_basic_hit();
        res_t o, e;
        do_lookup(32'h0000_1000, 4'h1, o);
        e = m_lookup(32'h0000_1000, 4'h1);
        vectors++;
        if (o !== e || o.hit !== 1'b0 || o.victim !== 2'd0) begin
            miscompares++; $display("FAIL basic_miss: got %h required %h", o, e);
        end
        do_write(0, 0, 24'h10, {16{8'hA5}}, 0);
        do_lookup(32'h0000_1000, 4'h2, o);
        e = m_lookup(32'h0000_1000, 4'h2);
        vectors++;
        if (o !== e || o.hit !== 1'b1 || o.way !== 2'd0 || o.data !== {16{8'hA5}} || o.victim !== 2'd1) begin
            miscompares++; $display("FAIL basic_hit: got %h required %h", o, e);
        end
    endtask

    task automatic test_plru_index3();
        res_t o, e;
        for (int w = 0; w < WC; w++) do_write(3, w, 24'h100 + TW'(w), {4{$urandom}}, 0);
        do_lookup({24'h103, 8'h30}, 4'h3, o);
        e = m_lookup({24'h103, 8'h30}, 4'h3);
        vectors++;
        if (o !== e || o.hit !== 1'b1 || o.way !== 2'd3 || o.victim !== 2'd0) begin
            miscompares++; $display("FAIL plru_way3: got %h required %h", o, e);
        end
        do_lookup({24'h100, 8'h34}, 4'h4, o);
        e = m_lookup({24'h100, 8'h34}, 4'h4);
        vectors++;
        if (o !== e || o.hit !== 1'b1 || o.way !== 2'd0) begin
            miscompares++; $display("FAIL plru_way0: got %h required %h", o, e);
        end
        do_lookup({24'h101, 8'h38}, 4'h5, o);
        e = m_lookup({24'h101, 8'h38}, 4'h5);
        vectors++;
        if (o !== e || o.victim !== 2'd2) begin
            miscompares++; $display("FAIL plru_victim2: got %h required %h", o, e);
        end
    endtask

    task automatic test_write_priority();
        res_t o, e;
        logic [LW-1:0] d;
        d = {4{$urandom}};
        write_addr = 5; write_way = 1; write_tag = 24'h555; write_data = d; write_error = 0;
        write_valid = 1; in_addr = {24'h555, 8'h50}; in_id = 4'h6; in_valid = 1; out_ready = 1;
        tick();
        vectors++;
        if ({write_ready, in_ready} !== 2'b10) begin
            miscompares++; $display("FAIL wr_prio_ready: wr/in=%b required 10", {write_ready, in_ready});
        end
        tick();
        write_valid = 0; m_write(5, 1, 24'h555, d, 0); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL wr_prio_in_ready: got %b required 1", in_ready);
        end
        tick(); in_valid = 0;
        o = get_res(); e = m_lookup({24'h555, 8'h50}, 4'h6);
        vectors++;
        if (o !== e || o.hit !== 1'b1) begin
            miscompares++; $display("FAIL wr_prio_lookup: got %h required %h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t snap, e;
        logic [AW-1:0] a [6];
        a = '{32'h0000_1000, {24'h100, 8'h31}, {24'h102, 8'h32}, 32'h0000_2000,
              {24'h103, 8'h33}, {24'h555, 8'h54}};
        tick();
        out_ready = 0; in_addr = {24'h101, 8'h3C}; in_id = 4'h7; in_valid = 1;
        tick(); in_valid = 0;
        snap = get_res(); e = m_lookup({24'h101, 8'h3C}, 4'h7);
        vectors++;
        if (snap !== e) begin miscompares++; $display("FAIL stall_capture: got %h required %h", snap, e); end
        in_addr = a[0]; in_id = 4'h8; in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (in_ready !== 1'b0 || get_res() !== snap) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: in_ready=%b out=%h required 0/%h", c, in_ready, get_res(), snap);
            end
        end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_addr = a[i]; in_id = IW'(i); #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++; $display("FAIL b2b_ready %0d: got %b required 1", i, in_ready);
            end
            tick();
            e = m_lookup(a[i], IW'(i));
            vectors++;
            if (get_res() !== e) begin
                miscompares++; $display("FAIL b2b_result %0d: got %h required %h", i, get_res(), e);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_error_flush();
        res_t o, e;
        do_write(9, 2, 24'hE77, {4{$urandom}}, 1);
        do_lookup({24'hE77, 8'h90}, 4'h9, o);
        e = m_lookup({24'hE77, 8'h90}, 4'h9);
        vectors++;
        if (o !== e || o.hit !== 1'b1 || o.err !== 1'b1) begin
            miscompares++; $display("FAIL error_hit: got %h required %h", o, e);
        end
        flush_valid = 1; write_valid = 1; #1;
        vectors++;
        if ({flush_ready, write_ready, in_ready} !== 3'b100) begin
            miscompares++; $display("FAIL flush_prio: f/w/i=%b required 100", {flush_ready, write_ready, in_ready});
        end
        tick(); flush_valid = 0; write_valid = 0; m_clear();
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) tick();
            vectors++;
            if ({in_ready, write_ready, flush_ready} !== (c == 17 ? 3'b111 : 3'b000)) begin
                miscompares++;
                $display("FAIL flush_sweep cycle %0d: rdy=%b required %b", c, {in_ready, write_ready, flush_ready},
                         (c == 17 ? 3'b111 : 3'b000));
            end
        end
        do_lookup({24'hE77, 8'h90}, 4'hA, o);
        e = m_lookup({24'hE77, 8'h90}, 4'hA);
        vectors++;
        if (o !== e || o.hit !== 1'b0 || o.victim !== 2'd0) begin
            miscompares++; $display("FAIL flush_miss: got %h required %h", o, e);
        end
    endtask

    task automatic test_random();
        res_t o, e;
        int ixs [4] = '{2, 6, 11, 14};
        int ix, n;
        logic [AW-1:0] a;
        for (int k = 0; k < 300; k++) begin
            ix = ixs[$urandom_range(3)];
            n = $urandom_range(99);
            if (n < 2) begin
                flush_valid = 1; tick(); flush_valid = 0; m_clear();
                n = 0;
                while (!flush_ready && n < 40) begin tick(); n++; end
                if (!flush_ready) begin
                    vectors++; miscompares++;
                    $display("FAIL rand_flush_timeout: flush_ready=%b required 1", flush_ready);
                end
            end else if (n < 35) begin
                do_write(ix, $urandom_range(WC - 1), 24'h3000 + TW'($urandom_range(5)), {4{$urandom}},
                         1'($urandom_range(1)));
            end else begin
                a = mk_addr(24'h3000 + TW'($urandom_range(5)), ix);
                do_lookup(a, IW'(k), o);
                e = m_lookup(a, IW'(k));
                vectors++;
                if (o !== e) begin
                    miscompares++; $display("FAIL rand_lookup %0d: got %h required %h", k, o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_plru_index3();
        test_write_priority();
        test_back_to_back();
        test_error_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
